// File: rtl/display_sequencer.sv
// display_sequencer: turns three debounced buttons and an auto-advance prescaler
// into one-cycle commands for a digit FSM, tracking its position and blank state.
// Ports: clock/reset (async, active-high); btn_fwd, btn_back, btn_blank raw buttons;
// mode_auto enables forward steps on each tick; entradas command (00 hold, 01 fwd,
// 10 back, 11 blank); step_idx shadow position 0..8; blanked shadow blank flag;
// tick prescaler wrap pulse.
module display_sequencer #(
    parameter int DIV = 50000000,
    parameter int DEB = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_blank,
    input  logic       mode_auto,
    output logic [1:0] entradas,
    output logic [3:0] step_idx,
    output logic       blanked,
    output logic       tick
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW = (DEB > 1) ? $clog2(DEB + 1) : 1;
    typedef enum logic {RUN, BLANK} state_t;
    state_t state, state_nxt;
    logic [2:0] raw, sync1, sync2, deb, deb_q, ev;
    logic [CW-1:0] cnt [3];
    logic [PW-1:0] pcnt;
    logic [1:0] cmd;
    logic [3:0] step_nxt;
    // bit 0 fwd, bit 1 back, bit 2 blank
    assign raw = {btn_blank, btn_back, btn_fwd};
    assign ev = deb & ~deb_q;
    assign tick = pcnt == PW'(DIV - 1);
    assign blanked = state == BLANK;
    // synchronizers, debounce counters and the press-edge history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEB - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pcnt <= '0;
        else pcnt <= tick ? '0 : pcnt + 1'b1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            step_idx <= '0;
            entradas <= '0;
        end else begin
            state <= state_nxt;
            step_idx <= step_nxt;
            entradas <= cmd;
        end
    end
    always_comb begin
        state_nxt = ev[2] ? BLANK : (ev[1] | ev[0]) ? RUN : state;
    end
    // blank outranks back, back outranks fwd, fwd outranks the auto tick
    always_comb begin
        cmd = ev[2] ? (state == RUN ? 2'b11 : 2'b00) :
              ev[1] ? 2'b10 :
              ev[0] ? 2'b01 :
              (tick && mode_auto && state == RUN) ? 2'b01 : 2'b00;
        step_nxt = ev[2] ? step_idx :
                   state == BLANK ? ((ev[1] | ev[0]) ? 4'd0 : step_idx) :
                   ev[1] ? (step_idx == 4'd0 ? 4'd8 : step_idx - 4'd1) :
                   cmd[0] ? (step_idx == 4'd8 ? 4'd0 : step_idx + 4'd1) : step_idx;
    end
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed and random stimulus against a behavioural model.
module tb_display_sequencer;
    localparam int DIV = 10;
    localparam int DEB = 4;
    localparam int HW = DEB + 2;
    logic clock = 0;
    logic reset = 1;
    logic btn_fwd = 0, btn_back = 0, btn_blank = 0, mode_auto = 0;
    logic [1:0] entradas;
    logic [3:0] step_idx;
    logic blanked, tick;
    int checks = 0, errors = 0, ncmd = 0, ntick = 0, last_cmd = 0;
    int c0, t0, n, rst_cnt;
    int tmr [3];
    logic [2:0] lvl;
    logic [HW-1:0] m_hist [3];
    logic [2:0] m_lvl = '0, m_ev = '0, raw;
    logic m_blk = 0, m_t;
    int m_p = 0, m_pos = 0, m_cmd = 0;

    display_sequencer #(.DIV(DIV), .DEB(DEB)) dut (
        .clock(clock), .reset(reset), .btn_fwd(btn_fwd), .btn_back(btn_back),
        .btn_blank(btn_blank), .mode_auto(mode_auto), .entradas(entradas),
        .step_idx(step_idx), .blanked(blanked), .tick(tick)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int k);
        repeat (k) begin
            @(posedge clock);
            #3;
        end
    endtask

    task automatic set_btn(int b, logic v);
        if (b == 0) btn_fwd = v;
        else if (b == 1) btn_back = v;
        else btn_blank = v;
    endtask

    task automatic press(int b, int hold);
        set_btn(b, 1);
        cyc(hold);
        set_btn(b, 0);
        cyc(DEB + 6);
    endtask

    // Model: a button level flips once the last DEB synchronized samples (raw delayed
    // two clocks) all disagree with it; a rise is a press acted on one clock later.
    initial forever begin
        @(posedge clock);
        if (reset) begin
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
            m_lvl = '0;
            m_ev = '0;
            m_p = 0;
            m_pos = 0;
            m_blk = 0;
            m_cmd = 0;
        end else begin
            m_t = (m_p == DIV - 1);
            m_cmd = 0;
            if (m_ev[2]) begin
                if (!m_blk) begin
                    m_cmd = 3;
                    m_blk = 1;
                end
            end else if (m_ev[1]) begin
                m_cmd = 2;
                m_pos = m_blk ? 0 : (m_pos + 8) % 9;
                m_blk = 0;
            end else if (m_ev[0]) begin
                m_cmd = 1;
                m_pos = m_blk ? 0 : (m_pos + 1) % 9;
                m_blk = 0;
            end else if (m_t && mode_auto && !m_blk) begin
                m_cmd = 1;
                m_pos = (m_pos + 1) % 9;
            end
            raw = {btn_blank, btn_back, btn_fwd};
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][HW-2:0], raw[b]};
                if (m_hist[b][HW-1:2] == {DEB{~m_lvl[b]}}) begin
                    m_ev[b] = ~m_lvl[b];
                    m_lvl[b] = ~m_lvl[b];
                end else m_ev[b] = 0;
            end
            m_p = (m_p + 1) % DIV;
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        if (!reset) begin
            chk("entradas", entradas, m_cmd);
            chk("step_idx", step_idx, m_pos);
            chk("blanked", blanked, m_blk);
            chk("tick", tick, m_p == DIV - 1);
            if (entradas != 0) begin
                ncmd++;
                last_cmd = entradas;
            end
            if (tick) ntick++;
        end
    end

    initial begin
        cyc(3);
        chk("rst_entradas", entradas, 0);
        chk("rst_step", step_idx, 0);
        chk("rst_blanked", blanked, 0);
        chk("rst_tick", tick, 0);
        reset = 0;
        cyc(2);
        // single fwd press: latency 2 + DEB + 1
        c0 = ncmd;
        btn_fwd = 1;
        n = 0;
        while (entradas != 2'b01 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("fwd_latency", n, 7);
        cyc(12 - n);
        btn_fwd = 0;
        cyc(DEB + 6);
        chk("fwd_pulses", ncmd - c0, 1);
        chk("fwd_step", step_idx, 1);
        // back wrap and nine forwards
        press(1, 8);
        chk("back_step0", step_idx, 0);
        press(1, 8);
        chk("back_wrap", step_idx, 8);
        chk("back_cmd", last_cmd, 2);
        press(0, 8);
        chk("fwd_wrap", step_idx, 0);
        for (int i = 0; i < 9; i++) press(0, 8);
        chk("nine_fwd", step_idx, 0);
        // glitch
        c0 = ncmd;
        press(0, 3);
        chk("glitch_cmds", ncmd - c0, 0);
        chk("glitch_step", step_idx, 0);
        // auto advance
        c0 = ncmd;
        t0 = ntick;
        mode_auto = 1;
        cyc(100);
        mode_auto = 0;
        chk("auto_ticks", ntick - t0, 10);
        chk("auto_cmds", ncmd - c0, 10);
        chk("auto_step", step_idx, 1);
        // blank at 5, auto suppressed, back exits to 0
        for (int i = 0; i < 4; i++) press(0, 8);
        chk("pre_blank_step", step_idx, 5);
        c0 = ncmd;
        press(2, 8);
        chk("blank_cmds", ncmd - c0, 1);
        chk("blank_cmd", last_cmd, 3);
        chk("blank_flag", blanked, 1);
        chk("blank_step", step_idx, 5);
        c0 = ncmd;
        mode_auto = 1;
        cyc(30);
        mode_auto = 0;
        chk("blank_quiet", ncmd - c0, 0);
        chk("blank_hold", blanked, 1);
        press(1, 8);
        chk("unblank_cmd", last_cmd, 2);
        chk("unblank_step", step_idx, 0);
        chk("unblank_flag", blanked, 0);
        // simultaneous fwd + blank
        c0 = ncmd;
        btn_fwd = 1;
        btn_blank = 1;
        cyc(10);
        btn_fwd = 0;
        btn_blank = 0;
        cyc(DEB + 6);
        chk("simul_cmds", ncmd - c0, 1);
        chk("simul_cmd", last_cmd, 3);
        chk("simul_blank", blanked, 1);
        press(0, 8);
        chk("exit_fwd_step", step_idx, 0);
        chk("exit_fwd_flag", blanked, 0);
        // reset mid-debounce
        c0 = ncmd;
        btn_fwd = 1;
        cyc(4);
        reset = 1;
        cyc(2);
        btn_fwd = 0;
        cyc(1);
        reset = 0;
        cyc(20);
        chk("rst_mid_cmds", ncmd - c0, 0);
        // button held through reset release
        btn_back = 1;
        reset = 1;
        cyc(3);
        reset = 0;
        c0 = ncmd;
        cyc(15);
        chk("held_cmds", ncmd - c0, 1);
        chk("held_cmd", last_cmd, 2);
        chk("held_step", step_idx, 8);
        btn_back = 0;
        cyc(DEB + 6);
        // random phase
        rst_cnt = 0;
        for (int b = 0; b < 3; b++) tmr[b] = 0;
        lvl = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (tmr[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    tmr[b] = $urandom_range(1, 3 * DEB);
                end
                tmr[b]--;
            end
            {btn_blank, btn_back, btn_fwd} = lvl;
            if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom_range(0, 599) == 0) rst_cnt = $urandom_range(1, 3);
            reset = rst_cnt > 0;
            cyc(1);
        end
        reset = 0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter DIV, default 50000000, clock cycles per auto-advance tick (minimum 2).
REQ-002 Parameter DEB, default 1000000, clock cycles a synchronized button level must stay stable to be accepted (minimum 1).
REQ-003 Port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port btn_fwd  input  1  raw forward button, active-high, asynchronous to clock.
REQ-006 Port btn_back  input  1  raw back button, active-high, asynchronous to clock.
REQ-007 Port btn_blank  input  1  raw blank button, active-high, asynchronous to clock.
REQ-008 Port mode_auto  input  1  level; 1 = auto-advance forward on every tick.
REQ-009 Port entradas  output  2  registered one-cycle command to the digit FSM: 00 hold, 01 forward, 10 back, 11 blank.
REQ-010 Port step_idx  output  4  shadow position 0..8 of the digit FSM.
REQ-011 Port blanked  output  1  1 while the shadow state is blank.
REQ-012 Port tick  output  1  one-cycle pulse at each prescaler wrap.

Function
REQ-013 Each button passes through a 2-flop synchronizer, then a per-button debounce counter; the debounced level changes only after DEB consecutive equal synchronized samples.
REQ-014 A press event is a 0->1 transition of the debounced level; exactly one event per press, regardless of hold length.
REQ-015 Prescaler counts 0..DIV-1 and wraps; tick = 1 in the cycle the counter equals DIV-1; it free-runs in all states.
REQ-016 FSM states: RUN and BLANK.
REQ-017 Priority within a cycle: blank event > back event > fwd event > auto tick; lower-priority events in the same cycle are discarded, not queued.
REQ-018 RUN, blank event -> entradas=11, go to BLANK, step_idx unchanged.
REQ-019 RUN, back event -> entradas=10, step_idx decrements, 0 wraps to 8.
REQ-020 RUN, fwd event, or tick with mode_auto=1 -> entradas=01, step_idx increments, 8 wraps to 0.
REQ-021 BLANK, fwd or back event -> entradas=01 for fwd and 10 for back, step_idx=0, go to RUN.
REQ-022 BLANK, blank event or tick -> entradas=00, no state change (auto-advance suppressed while blanked).
REQ-023 entradas is registered and returns to 00 the cycle after any command; never two non-00 commands in consecutive cycles from the same event.
REQ-024 blanked = 1 exactly while state is BLANK.
REQ-025 Latency: entradas asserts on the clock edge that registers the event; button press to command is 2 + DEB + 1 cycles.

Reset
REQ-026 While reset=1: state RUN, step_idx=0, entradas=00, blanked=0, tick=0, prescaler=0, synchronizers, debounced levels and debounce counters=0.
REQ-027 Reset asserted mid-debounce or mid-command discards all pending events; no command is emitted on release.
REQ-028 After release, a button already held high generates one press event once debounced.

Verification (DIV=10, DEB=4)
REQ-029 Pulse btn_fwd for 12 cycles -> exactly one entradas=01 pulse 7 cycles after the rising edge; step_idx 0->1.
REQ-030 Press btn_back from step_idx=0 -> entradas=10, step_idx=8; nine fwd presses from 0 -> step_idx returns to 0.
REQ-031 btn_fwd glitch of 3 cycles -> no command, step_idx unchanged.
REQ-032 mode_auto=1 for 100 cycles -> tick every 10 cycles, 10 entradas=01 pulses, step_idx advances 0->1->...->8->0->1.
REQ-033 Blank press at step_idx=5, then 30 cycles with mode_auto=1, then back press -> entradas=11, blanked=1, no commands while blanked, then entradas=10, step_idx=0, blanked=0.
REQ-034 Simultaneous debounced fwd and blank rising edges -> only entradas=11; reset asserted 2 cycles into debounce -> no command after release.
